// File: rtl/dct_pkg.sv
// Shared constants and index helper for the 8x8 DCT transpose buffer.
// The transpose is a pure bit-field swap because N is a power of two.
package dct_pkg;

    localparam int DCT_N     = 8;
    localparam int DCT_BLK   = 64;
    localparam int DCT_IDX_W = 6;
    localparam int DCT_ROW_W = 3;

    // Raster index r*N+c becomes column-major index c*N+r
    function automatic logic [DCT_IDX_W-1:0] dct_tpose_idx(input logic [DCT_IDX_W-1:0] idx);
        return {idx[DCT_ROW_W-1:0], idx[DCT_IDX_W-1:DCT_ROW_W]};
    endfunction

endpackage

// File: rtl/dct_tpose_bank.sv
// One N*N-entry coefficient bank: synchronous write, combinational read.
// Contents are deliberately left unreset; bank validity is tracked by the owner.
module dct_tpose_bank
    import dct_pkg::*;
#(
    parameter int bit_width = 16,
    parameter int depth     = DCT_BLK,
    parameter int idx_w     = DCT_IDX_W
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [idx_w-1:0]     waddr,
    input  logic [bit_width-1:0] wdata,
    input  logic [idx_w-1:0]     raddr,
    output logic [bit_width-1:0] rdata
);

    logic [bit_width-1:0] mem_r [depth];

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer: raster-order writes into one bank while the
// other bank is read out column-major through a registered output stage.
module dct_transpose_buffer
    import dct_pkg::*;
#(
    parameter int bit_width = 16,
    parameter int N         = DCT_N
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [bit_width-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [bit_width-1:0] out_data,
    output logic                 out_last
);

    localparam int ROW_W = $clog2(N);
    localparam int IDX_W = 2 * ROW_W;
    localparam int BLK   = N * N;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
    localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(0);

    logic [1:0]           full_r;
    logic [1:0]           full_nxt_s;
    logic                 wr_bank_r;
    logic                 rd_bank_r;
    logic [IDX_W-1:0]     wr_cnt_r;
    logic [IDX_W-1:0]     rd_cnt_r;
    logic                 out_valid_r;
    logic                 out_last_r;
    logic [bit_width-1:0] out_data_r;

    logic                 wr_en_s;
    logic                 wr_done_s;
    logic                 rd_load_s;
    logic                 rd_done_s;
    logic [IDX_W-1:0]     rd_idx_s;
    logic [bit_width-1:0] rd_data_s;
    logic [bit_width-1:0] bank0_rdata_s;
    logic [bit_width-1:0] bank1_rdata_s;

    // Column-major read address: swap the row and column halves of rd_cnt
    generate
        if (N == DCT_N) begin : g_pkg_idx
            assign rd_idx_s = IDX_W'(dct_tpose_idx(DCT_IDX_W'(rd_cnt_r)));
        end else begin : g_gen_idx
            assign rd_idx_s = {rd_cnt_r[ROW_W-1:0], rd_cnt_r[IDX_W-1:ROW_W]};
        end
    endgenerate

    // Handshake decode, bank read mux and next bank-full flags
    always_comb begin
        wr_en_s   = in_valid && !full_r[wr_bank_r];
        wr_done_s = wr_en_s && (wr_cnt_r == LAST_IDX);
        rd_load_s = full_r[rd_bank_r] && (!out_valid_r || out_ready);
        rd_done_s = rd_load_s && (rd_cnt_r == LAST_IDX);

        if (rd_bank_r) begin
            rd_data_s = bank1_rdata_s;
        end else begin
            rd_data_s = bank0_rdata_s;
        end

        // Writer and reader never complete the same bank in one cycle
        full_nxt_s = full_r;
        if (wr_done_s) begin
            full_nxt_s[wr_bank_r] = 1'b1;
        end else begin
            full_nxt_s[wr_bank_r] = full_r[wr_bank_r];
        end
        if (rd_done_s) begin
            full_nxt_s[rd_bank_r] = 1'b0;
        end else begin
            full_nxt_s[rd_bank_r] = full_nxt_s[rd_bank_r];
        end
    end

    // Bank flags plus write and read position counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r    <= 2'b00;
            wr_bank_r <= 1'b0;
            rd_bank_r <= 1'b0;
            wr_cnt_r  <= ZERO_IDX;
            rd_cnt_r  <= ZERO_IDX;
        end else begin
            full_r <= full_nxt_s;
            if (wr_done_s) begin
                wr_cnt_r  <= ZERO_IDX;
                wr_bank_r <= ~wr_bank_r;
            end else if (wr_en_s) begin
                wr_cnt_r <= wr_cnt_r + ONE_IDX;
            end
            if (rd_done_s) begin
                rd_cnt_r  <= ZERO_IDX;
                rd_bank_r <= ~rd_bank_r;
            end else if (rd_load_s) begin
                rd_cnt_r <= rd_cnt_r + ONE_IDX;
            end
        end
    end

    // Output stage: load the next transposed sample, hold under back-pressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= {bit_width{1'b0}};
        end else if (rd_load_s) begin
            out_valid_r <= 1'b1;
            out_last_r  <= (rd_cnt_r == LAST_IDX);
            out_data_r  <= rd_data_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    dct_tpose_bank #(
        .bit_width (bit_width),
        .depth     (BLK),
        .idx_w     (IDX_W)
    ) u_bank0 (
        .clk   (clk),
        .we    (wr_en_s && !wr_bank_r),
        .waddr (wr_cnt_r),
        .wdata (in_data),
        .raddr (rd_idx_s),
        .rdata (bank0_rdata_s)
    );

    dct_tpose_bank #(
        .bit_width (bit_width),
        .depth     (BLK),
        .idx_w     (IDX_W)
    ) u_bank1 (
        .clk   (clk),
        .we    (wr_en_s && wr_bank_r),
        .waddr (wr_cnt_r),
        .wdata (in_data),
        .raddr (rd_idx_s),
        .rdata (bank1_rdata_s)
    );

    assign in_ready  = !full_r[wr_bank_r];
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Directed bench for dct_transpose_buffer: inputs driven and outputs sampled
// on the falling edge, expected values computed from the raster/column-major rule.
module tb_dct_transpose_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;

    int vectors     = 0;
    int miscompares = 0;
    logic [15:0] blk [64];

    dct_transpose_buffer #(
        .bit_width (16),
        .N         (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output j of a block is raster sample (j mod 8)*8 + j/8
    function automatic logic [15:0] tpose_exp(input int j);
        return blk[(j % 8) * 8 + j / 8];
    endfunction

    task automatic send_blk(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int w;
            in_valid = 1'b1;
            in_data  = blk[i];
            w = 0;
            while (!in_ready && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (w >= 200) chk("send_timeout", 32'd0, 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic recv_blk(input string tag);
        for (int j = 0; j < 64; j++) begin
            int w;
            w = 0;
            while (!out_valid && w < 200) begin
                @(negedge clk);
                w++;
            end
            chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_data"}, {16'd0, out_data}, {16'd0, tpose_exp(j)});
            chk({tag, "_last"}, {31'd0, out_last}, {31'd0, (j == 63)});
            @(negedge clk);
        end
    endtask

    initial begin
        logic [15:0] pat;
        int acc;
        int n;
        int c;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'd0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single block 0..63, latency and transposed order
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) blk[i] = 16'(i);
        send_blk(64);
        chk("t1_lat_edge_k", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("t1_lat_edge_k1", {31'd0, out_valid}, 32'd1);
        recv_blk("t1");
        chk("t1_idle", {31'd0, out_valid}, 32'd0);

        // Two back-to-back blocks with continuous input and output
        for (int t = 0; t <= 192; t++) begin
            if (t < 128) begin
                in_valid = 1'b1;
                in_data  = (t < 64) ? 16'(t) : 16'(100 + t - 64);
                chk("t2_in_ready", {31'd0, in_ready}, 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            if (t >= 65) begin
                int j;
                int m;
                j = t - 65;
                m = j % 64;
                chk("t2_valid", {31'd0, out_valid}, 32'd1);
                chk("t2_data", {16'd0, out_data},
                    32'((j / 64) * 100 + (m % 8) * 8 + m / 8));
                chk("t2_last", {31'd0, out_last}, {31'd0, (m == 63)});
            end else begin
                chk("t2_pre_valid", {31'd0, out_valid}, 32'd0);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("t2_idle", {31'd0, out_valid}, 32'd0);

        // Output stalled: only two blocks fit, then drain in column order
        out_ready = 1'b0;
        acc = 0;
        for (int t = 0; t < 200; t++) begin
            in_valid = 1'b1;
            in_data  = 16'(t);
            if (in_ready) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("t3_accepted", 32'(acc), 32'd128);
        chk("t3_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("t3_hold_data", {16'd0, out_data}, 32'd0);
        out_ready = 1'b1;
        for (int j = 0; j < 128; j++) begin
            int m;
            m = j % 64;
            chk("t3_valid", {31'd0, out_valid}, 32'd1);
            chk("t3_data", {16'd0, out_data}, 32'((j / 64) * 64 + (m % 8) * 8 + m / 8));
            chk("t3_last", {31'd0, out_last}, {31'd0, (m == 63)});
            if (j == 62) chk("t3_both_full", {31'd0, in_ready}, 32'd0);
            if (j == 63) chk("t3_bank_freed", {31'd0, in_ready}, 32'd1);
            @(negedge clk);
        end
        chk("t3_idle", {31'd0, out_valid}, 32'd0);

        // Irregular out_ready: held outputs must keep matching the model
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) blk[i] = 16'(16'h1000 + i * 3);
        send_blk(64);
        pat = 16'b1011_0010_1110_0100;
        n = 0;
        c = 0;
        while (n < 64 && c < 400) begin
            if (out_valid) begin
                chk("t4_hold_data", {16'd0, out_data}, {16'd0, tpose_exp(n)});
                chk("t4_hold_last", {31'd0, out_last}, {31'd0, (n == 63)});
            end
            out_ready = pat[c % 16];
            if (out_valid && out_ready) n++;
            c++;
            @(negedge clk);
        end
        chk("t4_count", 32'(n), 32'd64);

        // Signed extremes pass bit-exact through the transpose
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) blk[i] = 16'(i * 257);
        blk[1] = 16'h8000;
        blk[8] = 16'h7FFF;
        send_blk(64);
        @(negedge clk);
        recv_blk("t5");

        // Reset mid-block discards a full bank and a partial one
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) blk[i] = 16'(16'hA000 + i);
        send_blk(64);
        @(negedge clk);
        chk("t6_pre_valid", {31'd0, out_valid}, 32'd1);
        send_blk(30);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_data", {16'd0, out_data}, 32'd0);
        chk("t6_rst_last", {31'd0, out_last}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_release_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("t6_no_stale", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) blk[i] = 16'(i);
        send_blk(64);
        chk("t6_lat_edge_k", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        recv_blk("t6");
        chk("t6_idle", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
